// File: rtl/pixel_ctrl_pkg.sv
// Shared constants, FSM state encoding and Gray-code helpers for the
// pixel array controller.
package pixel_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int N_PIX  = 4;
    localparam int IDX_W  = $clog2(N_PIX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_TURN,
        S_RD_SETTLE,
        S_RD_CAPTURE,
        S_RD_HOLD
    } state_t;

    function automatic logic [DATA_W-1:0] gray_encode(input logic [DATA_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [DATA_W-1:0] gray_decode(input logic [DATA_W-1:0] gray);
        logic [DATA_W-1:0] bin;
        bin[DATA_W-1] = gray[DATA_W-1];
        for (int i = DATA_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/pixel_adc_counter.sv
// 8-bit ADC ramp counter with synchronous clear and enable.
// Build option: GRAY_COUNT_EN makes the bus code Gray instead of binary.
module pixel_adc_counter
    import pixel_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              en,
    output logic [DATA_W-1:0] count,
    output logic [DATA_W-1:0] code
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + DATA_W'(1);
        end
    end

`ifdef GRAY_COUNT_EN
    assign code = gray_encode(count);
`else
    assign code = count;
`endif

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer and pixel readout engine for the 4-pixel sensor array.
// Build option: GRAY_COUNT_EN selects a Gray-coded ramp and Gray decode on capture.
module pixel_array_ctrl
    import pixel_ctrl_pkg::*;
#(
    parameter int unsigned ERASE_CYCLES  = 5,
    parameter int unsigned EXPOSE_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic              erase,
    output logic              expose,
    output logic              convert,
    output logic [N_PIX-1:0]  read,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic [DATA_W-1:0] data_in,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [DATA_W-1:0] pix_data,
    output logic [IDX_W-1:0]  pix_idx
);

    localparam logic [15:0] ERASE_LAST  = 16'(ERASE_CYCLES - 1);
    localparam logic [15:0] EXPOSE_LAST = 16'(EXPOSE_CYCLES - 1);

    state_t            state, state_next;
    logic [15:0]       phase_cnt;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] adc_count;
    logic [DATA_W-1:0] adc_code;
    logic [DATA_W-1:0] cap_data;
    logic              accept;
    logic              last_accept;

    assign accept      = (state == S_RD_HOLD) && pix_ready;
    assign last_accept = accept && (rd_idx == IDX_W'(N_PIX - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: next state defaults to the current one so no path through this block infers a latch.
        state_next = state;
        case (state)
            S_IDLE:       if (start) state_next = S_ERASE;
            S_ERASE:      if (phase_cnt == ERASE_LAST) state_next = S_EXPOSE;
            S_EXPOSE:     if (phase_cnt == EXPOSE_LAST) state_next = S_CONVERT;
            S_CONVERT:    if (adc_count == '1) state_next = S_TURN;
            S_TURN:       state_next = S_RD_SETTLE;
            S_RD_SETTLE:  state_next = S_RD_CAPTURE;
            S_RD_CAPTURE: state_next = S_RD_HOLD;
            S_RD_HOLD: begin
                if (last_accept) begin
                    state_next = S_IDLE;
                end else if (accept) begin
                    state_next = S_RD_SETTLE;
                end
            end
            default:      state_next = S_IDLE;
        endcase
    end

    // Phase timer restarts on every state change and only runs during erase/expose.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_cnt <= '0;
        end else if (state_next != state) begin
            phase_cnt <= '0;
        end else if (state == S_ERASE || state == S_EXPOSE) begin
            phase_cnt <= phase_cnt + 16'd1;
        end
    end

    pixel_adc_counter u_adc_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state != S_CONVERT),
        .en      (state == S_CONVERT),
        .count   (adc_count),
        .code    (adc_code)
    );

`ifdef GRAY_COUNT_EN
    assign cap_data = gray_decode(data_in);
`else
    assign cap_data = data_in;
`endif

    // NOTE: every register takes the async reset so all outputs clear the moment reset_n falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_idx     <= '0;
            pix_data   <= '0;
            pix_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_accept;
            if (state == S_TURN) begin
                rd_idx <= '0;
            end else if (accept) begin
                rd_idx <= rd_idx + IDX_W'(1);
            end
            if (state == S_RD_CAPTURE) begin
                pix_data <= cap_data;
                pix_idx  <= rd_idx;
            end
        end
    end

    assign busy      = (state != S_IDLE);
    assign erase     = (state == S_ERASE);
    assign expose    = (state == S_EXPOSE);
    assign convert   = (state == S_CONVERT);
    assign data_oe   = (state == S_CONVERT);
    assign data_out  = data_oe ? adc_code : '0;
    assign pix_valid = (state == S_RD_HOLD);

    // Strobes are decoded from state, so they can never overlap the CONVERT drive.
    always_comb begin
        read = '0;
        if (state == S_RD_SETTLE || state == S_RD_CAPTURE) begin
            read[rd_idx] = 1'b1;
        end
    end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Directed self-checking bench for pixel_array_ctrl (ERASE_CYCLES=2, EXPOSE_CYCLES=3).
// Expected values follow GRAY_COUNT_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_pixel_array_ctrl;

    localparam int E = 2;
    localparam int X = 3;

`ifdef GRAY_COUNT_EN
    localparam logic [7:0] CODE5 = 8'h07;
    localparam logic [7:0] CAP7  = 8'd5;
`else
    localparam logic [7:0] CODE5 = 8'h05;
    localparam logic [7:0] CAP7  = 8'd7;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       busy;
    logic       frame_done;
    logic       erase;
    logic       expose;
    logic       convert;
    logic [3:0] read;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] data_in;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_data;
    logic [1:0] pix_idx;

    logic [7:0] pv [4];
    int checks = 0;
    int errors = 0;
    int fd_count = 0;
    int overlap_count = 0;
    int fd_before;

    pixel_array_ctrl #(
        .ERASE_CYCLES  (E),
        .EXPOSE_CYCLES (X)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .erase      (erase),
        .expose     (expose),
        .convert    (convert),
        .read       (read),
        .data_out   (data_out),
        .data_oe    (data_oe),
        .data_in    (data_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_idx    (pix_idx)
    );

    always #5 clk = ~clk;

    // Sensor array model: the strobed pixel drives its latched value onto the bus.
    always_comb begin
        data_in = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (read[i]) data_in = pv[i];
        end
    end

    always @(negedge clk) begin
        if (frame_done) fd_count <= fd_count + 1;
        if (data_oe && (read != 4'b0)) overlap_count <= overlap_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_code(input int k);
        logic [7:0] b;
        b = 8'(k);
`ifdef GRAY_COUNT_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    function automatic logic [31:0] all_outputs();
        return 32'({busy, frame_done, erase, expose, convert, read, data_out,
                    data_oe, pix_valid, pix_data, pix_idx});
    endfunction

    // Called in an IDLE cycle; returns in the first CONVERT cycle.
    task automatic run_front(input bit pulse_in_expose);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= E; c++) begin
            check("erase_hi", 32'(erase), 32'(1));
            check("erase_expose_lo", 32'(expose), 32'(0));
            check("erase_busy", 32'(busy), 32'(1));
            tick();
        end
        for (int c = 1; c <= X; c++) begin
            check("expose_hi", 32'(expose), 32'(1));
            check("expose_erase_lo", 32'(erase), 32'(0));
            start = (pulse_in_expose && c == 2);
            tick();
        end
        start = 1'b0;
    endtask

    // Returns in the TURN cycle, or in the CONVERT cycle of count stop_at.
    task automatic run_ramp(input int stop_at);
        for (int k = 0; k < 256; k++) begin
            check("ramp_convert", 32'(convert), 32'(1));
            check("ramp_oe", 32'(data_oe), 32'(1));
            check("ramp_data", 32'(data_out), 32'(exp_code(k)));
            if (k == 5) check("code5", 32'(data_out), 32'(CODE5));
            if (k == stop_at) return;
            tick();
        end
        check("turn_oe", 32'(data_oe), 32'(0));
        check("turn_read", 32'(read), 32'(0));
        check("turn_convert", 32'(convert), 32'(0));
        check("turn_busy", 32'(busy), 32'(1));
        tick();
    endtask

    // Called in the RD_SETTLE cycle; returns in the cycle after acceptance.
    task automatic read_pixel(input int i, input logic [7:0] exp, input int stall,
                              input bit pulse_start);
        check("settle_read", 32'(read), 32'(1) << i);
        check("settle_valid", 32'(pix_valid), 32'(0));
        tick();
        check("capture_read", 32'(read), 32'(1) << i);
        if (stall > 0) pix_ready = 1'b0;
        tick();
        check("hold_valid", 32'(pix_valid), 32'(1));
        check("hold_read", 32'(read), 32'(0));
        check("hold_data", 32'(pix_data), 32'(exp));
        check("hold_idx", 32'(pix_idx), 32'(i));
        for (int s = 0; s < stall; s++) begin
            tick();
            check("stall_valid", 32'(pix_valid), 32'(1));
            check("stall_read", 32'(read), 32'(0));
            check("stall_data", 32'(pix_data), 32'(exp));
            check("stall_idx", 32'(pix_idx), 32'(i));
        end
        pix_ready = 1'b1;
        start = pulse_start;
        tick();
        start = 1'b0;
    endtask

    task automatic run_readout(input logic [7:0] e0, input int stall1, input bit pulse2);
        read_pixel(0, e0, 0, 1'b0);
        read_pixel(1, 8'd20, stall1, 1'b0);
        read_pixel(2, 8'd30, 0, pulse2);
        read_pixel(3, 8'd40, 0, 1'b0);
        check("frame_done_hi", 32'(frame_done), 32'(1));
        check("done_busy_lo", 32'(busy), 32'(0));
        tick();
        check("frame_done_lo", 32'(frame_done), 32'(0));
    endtask

    initial begin
`ifdef GRAY_COUNT_EN
        pv[0] = 8'h0F; pv[1] = 8'h1E; pv[2] = 8'h11; pv[3] = 8'h3C;
`else
        pv[0] = 8'd10; pv[1] = 8'd20; pv[2] = 8'd30; pv[3] = 8'd40;
`endif
        reset_n   = 1'b0;
        start     = 1'b0;
        pix_ready = 1'b0;

        // Reset with random inputs
        for (int c = 0; c < 4; c++) begin
            start     = 1'($urandom_range(0, 1));
            pix_ready = 1'($urandom_range(0, 1));
            tick();
            check("reset_outputs", all_outputs(), 32'(0));
        end
        start     = 1'b0;
        pix_ready = 1'b1;
        reset_n   = 1'b1;
        tick();
        check("post_reset_outputs", all_outputs(), 32'(0));
        tick();
        check("post_reset_busy", 32'(busy), 32'(0));

        // Nominal frame
        fd_before = fd_count;
        run_front(1'b0);
        run_ramp(-1);
        run_readout(8'd10, 0, 1'b0);
        tick();
        check("nominal_one_done", 32'(fd_count - fd_before), 32'(1));

        // Backpressure on pixel 1, start pulses in EXPOSE and RD_HOLD
        fd_before = fd_count;
        run_front(1'b1);
        run_ramp(-1);
        run_readout(8'd10, 5, 1'b1);
        for (int c = 0; c < 10; c++) tick();
        check("ignored_start_idle", 32'(busy), 32'(0));
        check("ignored_start_one_done", 32'(fd_count - fd_before), 32'(1));

        // Reset at count 100 in CONVERT
        fd_before = fd_count;
        run_front(1'b0);
        run_ramp(100);
        check("pre_abort_data", 32'(data_out), 32'(exp_code(100)));
        reset_n = 1'b0;
        #1;
        check("abort_oe", 32'(data_oe), 32'(0));
        check("abort_convert", 32'(convert), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_data", 32'(data_out), 32'(0));
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("abort_no_done", 32'(fd_count - fd_before), 32'(0));
        check("abort_idle", 32'(busy), 32'(0));

        // Clean frame after abort, pixel 0 bus value 8'h07
        pv[0] = 8'h07;
        fd_before = fd_count;
        run_front(1'b0);
        run_ramp(-1);
        run_readout(CAP7, 0, 1'b0);
        tick();
        check("clean_one_done", 32'(fd_count - fd_before), 32'(1));
        check("no_bus_overlap", 32'(overlap_count), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_array_ctrl.md
# pixel_array_ctrl

Frame controller and readout engine for the 4-pixel sensor array. Sequences the array through erase, expose, convert and read phases. During conversion it drives the shared 8-bit DATA bus with the ADC ramp count. During readout it asserts each pixel's read strobe in turn, captures the latched value off the same bus and delivers it on a valid/ready stream to the downstream image pipeline.

## Interface
Parameters:
- ERASE_CYCLES, 5: cycles `erase` stays high.
- EXPOSE_CYCLES, 255: cycles `expose` stays high (16-bit range, ≥1).
- Fixed values, not parameters: DATA_W = 8, N_PIX = 4.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  frame request, sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel is accepted.
- erase  out  1  array ERASE.
- expose  out  1  array EXPOSE.
- convert  out  1  ramp enable, high during CONVERT.
- read  out  4  one-hot READ1..READ4 strobes.
- data_out  out  8  ADC count driven onto the DATA bus.
- data_oe  out  1  bus drive enable for data_out.
- data_in  in  8  DATA bus sampled value.
- pix_valid  out  1  pixel sample valid.
- pix_ready  in  1  downstream accept.
- pix_data  out  8  pixel value.
- pix_idx  out  2  pixel index 0..3.

## Operation
- States and transitions:
  - IDLE → ERASE on start.
  - ERASE → EXPOSE after ERASE_CYCLES.
  - EXPOSE → CONVERT after EXPOSE_CYCLES.
  - CONVERT → TURN after count 255.
  - TURN → RD_SETTLE.
  - RD_SETTLE → RD_CAPTURE → RD_HOLD.
  - RD_HOLD → RD_SETTLE for the next pixel on handshake, or → IDLE after pixel 3.
- CONVERT: 8-bit count runs 0..255, one step per cycle (256 cycles). `data_oe`=1 and `convert`=1 throughout.
- TURN: one bus-turnaround cycle. `data_oe`=0, no read strobe.
- RD_SETTLE: `read[i]`=1.
- RD_CAPTURE: `read[i]`=1. `data_in` is registered into `pix_data` and `pix_idx`=i.
- RD_HOLD: `read`=0 and `pix_valid`=1. Stays in RD_HOLD until `pix_valid && pix_ready`.
  - `pix_data` and `pix_idx` remain stable while stalled.
  - The next pixel's strobe never asserts before acceptance.
- `pix_valid` drops in the cycle after acceptance.
- After pixel 3 is accepted: `frame_done` pulses in the next cycle, together with the return to IDLE.
- `start` outside IDLE is ignored. It is not queued.
- `data_oe` and any `read` bit are never high in the same cycle.

## Timing
- Reset value of every output is 0; state is IDLE.
- reset_n low mid-frame forces outputs to 0 asynchronously, including `data_oe`. This abandons the frame with no `frame_done`.
- Cycle numbering with `start` high at cycle 0:
  - `erase` high in cycles 1..E, where E = ERASE_CYCLES.
  - `expose` high in cycles E+1..E+X, where X = EXPOSE_CYCLES.
  - CONVERT occupies cycles E+X+1..E+X+256; count k is driven at cycle E+X+1+k.
  - TURN occurs at cycle E+X+257.
  - `read[0]` is high at cycles E+X+258 and E+X+259.
  - First `pix_valid` is at cycle E+X+260.
- Minimum readout cost is 3 cycles per pixel when `pix_ready` is held high.

## Configuration
- GRAY_COUNT_EN defined:
  - `data_out` = bin ^ (bin >> 1), Gray code.
  - The captured `data_in` is Gray-decoded to binary before it reaches `pix_data`.
- GRAY_COUNT_EN undefined:
  - `data_out` = binary count.
  - `pix_data` = `data_in` unmodified.

## Structure
- Package `pixel_ctrl_pkg` holds:
  - DATA_W and N_PIX.
  - The state enum typedef.
  - Gray encode and decode functions.
- One sub-module, `pixel_adc_counter`: the 8-bit conversion counter with clear/enable and optional Gray output.
- The FSM, read sequencing and output register stay in the top module.

## Test plan
- Reset: hold reset_n low with random inputs → all outputs 0, busy 0. Release → still IDLE.
- Nominal frame, ERASE_CYCLES=2, EXPOSE_CYCLES=3, pix_ready=1, bus model latches counts 10/20/30/40 for pixels 0..3:
  - `erase` is high in cycles 1-2 and `expose` in cycles 3-5.
  - `data_out` counts 0..255 with `data_oe` high.
  - Output is pix_data 10,20,30,40 with idx 0..3.
  - Exactly one `frame_done`.
- Backpressure: pix_ready low for 5 cycles on pixel 1 → pix_data/pix_idx stable, pix_valid high, read[2] stays 0 until acceptance.
- `start` pulsed during EXPOSE and again during RD_HOLD → ignored; exactly one frame produced.
- reset_n asserted at count 100 in CONVERT → `data_oe` and `convert` go to 0 in the same cycle, no `frame_done`. The next `start` runs a clean frame.
- Code-format check:
  - With GRAY_COUNT_EN, count 5 drives 8'h07, and data_in 8'h07 captures as pix_data 5.
  - Without GRAY_COUNT_EN, count 5 drives 8'h05 and data_in 8'h07 gives pix_data 7.
